uart_xmt_fifo: RTL

UART_XMT_FIFO -- requirements
Module: uart_xmt_fifo

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_fifo_ram.sv | 49 ++++
 rtl/uart_xmt_fifo.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and the FIFO status bundle used by the transmit FIFO.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FIFO_DEPTH = 16;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } uart_fifo_status_t;

    // Flag state of an empty FIFO with no recorded errors.
    localparam uart_fifo_status_t UART_FIFO_STATUS_RST = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1,
        overflow:     1'b0,
        underflow:    1'b0
    };

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port FIFO storage: synchronous write, read port either registered
// (SYNC_RD=1, block-RAM style) or combinational (SYNC_RD=0, for first-word fall-through).
module uart_fifo_ram #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter bit SYNC_RD = 1'b1,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    // Storage is deliberately never reset so it maps onto RAM primitives.
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    generate
        if (SYNC_RD) begin : g_sync_rd
            logic [DATA_W-1:0] r_rd_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd_data <= '0;
                end else if (i_rd_en) begin
                    r_rd_data <= r_mem[i_rd_addr];
                end
            end

            assign o_rd_data = r_rd_data;
        end else begin : g_async_rd
            logic w_unused;

            assign w_unused  = rst ^ i_rd_en;
            assign o_rd_data = r_mem[i_rd_addr];
        end
    endgenerate

endmodule

// File: rtl/uart_xmt_fifo.sv
// UART transmit FIFO with registered status flags and sticky overflow/underflow.
// Define UART_XMT_FIFO_FWFT_EN for first-word fall-through reads (default: 1-cycle read latency).
module uart_xmt_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = UART_FIFO_DEPTH,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_CNT = PW'(AF_LVL);
    localparam logic [PW-1:0] AE_CNT = PW'(AE_LVL);

`ifdef UART_XMT_FIFO_FWFT_EN
    localparam bit SYNC_RD = 1'b0;
`else
    localparam bit SYNC_RD = 1'b1;
`endif

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_count;
    uart_fifo_status_t r_status;

    logic [PW-1:0]     w_wr_ptr_next;
    logic [PW-1:0]     w_rd_ptr_next;
    logic [PW-1:0]     w_count_next;
    uart_fifo_status_t w_status_next;
    logic              w_wr_accept;
    logic              w_rd_accept;
    logic              w_ovf_set;
    logic              w_udf_set;
    logic [DATA_W-1:0] w_ram_rd_data;

    // Flush takes priority over traffic and is not itself an error condition.
    assign w_wr_accept = wr_en && !r_status.full  && !flush;
    assign w_rd_accept = rd_en && !r_status.empty && !flush;
    assign w_ovf_set   = wr_en &&  r_status.full  && !flush;
    assign w_udf_set   = rd_en &&  r_status.empty && !flush;

    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        if (flush) begin
            w_wr_ptr_next = '0;
            w_rd_ptr_next = '0;
        end else begin
            if (w_wr_accept) begin
                w_wr_ptr_next = r_wr_ptr + 1'b1;
            end
            if (w_rd_accept) begin
                w_rd_ptr_next = r_rd_ptr + 1'b1;
            end
        end
    end

    // Flags come from the next pointers so they are registered alongside them.
    assign w_count_next = w_wr_ptr_next - w_rd_ptr_next;

    always_comb begin
        w_status_next              = r_status;
        w_status_next.empty        = (w_wr_ptr_next == w_rd_ptr_next);
        w_status_next.full         = (w_wr_ptr_next[AW-1:0] == w_rd_ptr_next[AW-1:0]) &&
                                     (w_wr_ptr_next[AW] != w_rd_ptr_next[AW]);
        w_status_next.almost_full  = (w_count_next >= AF_CNT);
        w_status_next.almost_empty = (w_count_next <= AE_CNT);
        // A new error wins over a coincident clear.
        w_status_next.overflow     = w_ovf_set || (r_status.overflow  && !err_clr);
        w_status_next.underflow    = w_udf_set || (r_status.underflow && !err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_status <= UART_FIFO_STATUS_RST;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            r_status <= w_status_next;
        end
    end

    uart_fifo_ram #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .SYNC_RD (SYNC_RD),
        .AW      (AW)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_accept),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_accept),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (w_ram_rd_data)
    );

`ifdef UART_XMT_FIFO_FWFT_EN
    assign rd_data = r_status.empty ? '0 : w_ram_rd_data;
`else
    assign rd_data = w_ram_rd_data;
`endif

    assign full         = r_status.full;
    assign empty        = r_status.empty;
    assign almost_full  = r_status.almost_full;
    assign almost_empty = r_status.almost_empty;
    assign overflow     = r_status.overflow;
    assign underflow    = r_status.underflow;
    assign count        = r_count;

endmodule
